trig_scope: RTL and testbench

Parametrised trigger-and-capture scope for logging internal FPGA signals into a circular buffer. Generalises the single-trigger capture path with configurable data width, buffer depth and holdoff width, a masked pattern-match trigger with level/edge modes, an explicit arm control and a valid/ready readout stream. Sits beside the logic under observation; its readout stream feeds a UART/JTAG dump path.

---
 rtl/trig_scope.sv | 171 +++++++++++++++++
 tb/tb_trig_scope.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trig_scope.sv
// Trigger-and-capture scope: circular sample buffer with masked pattern/external
// trigger, programmable post-trigger holdoff and a valid/ready readout stream.
module trig_scope #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDR_WIDTH    = 10,
  parameter int unsigned HOLDOFF_WIDTH = 20
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DATA_WIDTH-1:0]    i_data,
  input  logic                     i_ext_trigger,
  input  logic [1:0]               i_trig_mode,
  input  logic [DATA_WIDTH-1:0]    i_trig_mask,
  input  logic [DATA_WIDTH-1:0]    i_trig_value,
  input  logic [HOLDOFF_WIDTH-1:0] i_holdoff,
  input  logic                     i_arm,
  output logic [DATA_WIDTH-1:0]    o_rd_data,
  output logic                     o_rd_valid,
  input  logic                     i_rd_ready,
  output logic                     o_rd_last,
  output logic                     o_primed,
  output logic                     o_triggered,
  output logic                     o_stopped,
  output logic [ADDR_WIDTH-1:0]    o_trig_addr,
  output logic [2:0]               o_state
);
  localparam int unsigned DEPTH     = 1 << ADDR_WIDTH;
  localparam int unsigned CMP_WIDTH = (HOLDOFF_WIDTH > ADDR_WIDTH) ? HOLDOFF_WIDTH : ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST = '1;
  localparam logic [ADDR_WIDTH-1:0] ONE  = ADDR_WIDTH'(1);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] FILL    = 3'd1;
  localparam logic [2:0] ARMED   = 3'd2;
  localparam logic [2:0] HOLDOFF = 3'd3;
  localparam logic [2:0] STOPPED = 3'd4;
  localparam logic [2:0] READOUT = 3'd5;

  logic [2:0]            state;
  logic [ADDR_WIDTH-1:0] waddr, raddr, hcnt, heff, bcnt, trig_addr;
  logic                  match_q, primed, triggered, stopped, rd_valid, rd_last;
  logic [DATA_WIDTH-1:0] rd_data, ram_q;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  match, trig, we, rd_en;
  logic [CMP_WIDTH-1:0]  hold_ext;
  logic [ADDR_WIDTH-1:0] heff_now;

  always_comb begin
    match = ((i_data ^ i_trig_value) & i_trig_mask) == '0;
    trig  = 1'b0;
    case (i_trig_mode)
      2'b00:   trig = i_ext_trigger;
      2'b01:   trig = match;
      2'b10:   trig = match & ~match_q;
      default: trig = i_ext_trigger | match;
    endcase
    hold_ext = CMP_WIDTH'(i_holdoff);
    heff_now = (hold_ext > CMP_WIDTH'(LAST)) ? LAST : ADDR_WIDTH'(hold_ext);
    we       = ~i_arm & ((state == FILL) | (state == ARMED) | (state == HOLDOFF));
    // ram_q acts as a prefetch stage feeding the 1-deep output register
    rd_en    = (state == STOPPED) | ((state == READOUT) & (~rd_valid | i_rd_ready));
  end

  always_ff @(posedge clk) begin
    if (we)
      mem[waddr] <= i_data;
    if (rd_en)
      ram_q <= mem[raddr];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      waddr     <= '0;
      raddr     <= '0;
      hcnt      <= '0;
      heff      <= '0;
      bcnt      <= '0;
      trig_addr <= '0;
      match_q   <= 1'b0;
      primed    <= 1'b0;
      triggered <= 1'b0;
      stopped   <= 1'b0;
      rd_valid  <= 1'b0;
      rd_last   <= 1'b0;
      rd_data   <= '0;
    end else if (i_arm) begin
      state     <= FILL;
      waddr     <= '0;
      hcnt      <= '0;
      match_q   <= 1'b0;
      primed    <= 1'b0;
      triggered <= 1'b0;
      stopped   <= 1'b0;
      rd_valid  <= 1'b0;
      rd_last   <= 1'b0;
    end else begin
      match_q <= match;
      case (state)
        FILL: begin
          waddr <= waddr + ONE;
          if (waddr == LAST) begin
            primed <= 1'b1;
            state  <= ARMED;
          end
        end
        ARMED: begin
          waddr <= waddr + ONE;
          if (trig) begin
            triggered <= 1'b1;
            heff      <= heff_now;
            if (heff_now == '0) begin
              stopped   <= 1'b1;
              trig_addr <= LAST;
              raddr     <= waddr + ONE;
              state     <= STOPPED;
            end else begin
              hcnt  <= heff_now;
              state <= HOLDOFF;
            end
          end
        end
        HOLDOFF: begin
          waddr <= waddr + ONE;
          hcnt  <= hcnt - ONE;
          if (hcnt == ONE) begin
            stopped   <= 1'b1;
            trig_addr <= LAST - heff;
            raddr     <= waddr + ONE;
            state     <= STOPPED;
          end
        end
        STOPPED: begin
          raddr <= raddr + ONE;
          state <= READOUT;
        end
        READOUT: begin
          if (!rd_valid) begin
            rd_data  <= ram_q;
            rd_valid <= 1'b1;
            rd_last  <= 1'b0;
            bcnt     <= '0;
            raddr    <= raddr + ONE;
          end else if (i_rd_ready) begin
            if (rd_last) begin
              rd_valid <= 1'b0;
              rd_last  <= 1'b0;
              state    <= IDLE;
            end else begin
              rd_data <= ram_q;
              rd_last <= ((bcnt + ONE) == LAST);
              bcnt    <= bcnt + ONE;
              raddr   <= raddr + ONE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign o_rd_data   = rd_data;
  assign o_rd_valid  = rd_valid;
  assign o_rd_last   = rd_last;
  assign o_primed    = primed;
  assign o_triggered = triggered;
  assign o_stopped   = stopped;
  assign o_trig_addr = trig_addr;
  assign o_state     = state;
endmodule

// File: tb/tb_trig_scope.sv
// Self-checking bench for trig_scope: a write-index model of the capture window
// derives trigger point, stop point and expected readout from the stimulus arrays.
module tb_trig_scope;
  localparam int DEPTH = 16;
  localparam int NARR  = 256;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  i_data, i_trig_mask, i_trig_value;
  logic        i_ext_trigger, i_arm, i_rd_ready;
  logic [1:0]  i_trig_mode;
  logic [19:0] i_holdoff;
  logic [7:0]  o_rd_data;
  logic        o_rd_valid, o_rd_last, o_primed, o_triggered, o_stopped;
  logic [3:0]  o_trig_addr;
  logic [2:0]  o_state;

  trig_scope #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .HOLDOFF_WIDTH(20)) dut (
    .clk(clk), .reset(rst_n), .i_data(i_data), .i_ext_trigger(i_ext_trigger),
    .i_trig_mode(i_trig_mode), .i_trig_mask(i_trig_mask), .i_trig_value(i_trig_value),
    .i_holdoff(i_holdoff), .i_arm(i_arm), .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid),
    .i_rd_ready(i_rd_ready), .o_rd_last(o_rd_last), .o_primed(o_primed),
    .o_triggered(o_triggered), .o_stopped(o_stopped), .o_trig_addr(o_trig_addr),
    .o_state(o_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0]  data_arr [NARR];
  logic        ext_arr  [NARR];
  logic [1:0]  mode;
  logic [19:0] hold;
  logic [7:0]  mask, value;
  int          trig_idx, heff, last_idx;
  logic [7:0]  exp_beats [DEPTH];

  function automatic bit pmatch(int n);
    return ((data_arr[n] ^ value) & mask) == 8'h00;
  endfunction

  // Writes are numbered from 0 after the arm; the trigger is the first qualifying
  // write once DEPTH writes have filled the buffer.
  task automatic compute_model();
    bit t;
    trig_idx = -1;
    for (int n = DEPTH; n < 200 && trig_idx < 0; n++) begin
      case (mode)
        2'd0:    t = ext_arr[n];
        2'd1:    t = pmatch(n);
        2'd2:    t = pmatch(n) && !pmatch(n - 1);
        default: t = ext_arr[n] || pmatch(n);
      endcase
      if (t) trig_idx = n;
    end
    checks++;
    if (trig_idx < 0) begin
      errors++;
      $display("FAIL model_trigger: no trigger in stimulus, required one before write 200");
      trig_idx = 199;
    end
    heff     = (hold > 20'd15) ? 15 : int'(hold);
    last_idx = trig_idx + heff;
    for (int b = 0; b < DEPTH; b++) exp_beats[b] = data_arr[last_idx - DEPTH + 1 + b];
  endtask

  task automatic fill_count(int ext_at);
    for (int n = 0; n < NARR; n++) begin
      data_arr[n] = 8'(n);
      ext_arr[n]  = (ext_at < 0) ? 1'b1 : (n == ext_at);
    end
  endtask

  task automatic arm_pulse();
    @(negedge clk);
    i_trig_mode = mode; i_trig_mask = mask; i_trig_value = value; i_holdoff = hold;
    i_rd_ready = 1'b0; i_arm = 1'b1;
    @(negedge clk);
    i_arm = 1'b0;
    checks++;
    if ({o_state, o_primed, o_triggered, o_stopped, o_rd_valid} !== {3'd1, 4'b0000}) begin
      errors++;
      $display("FAIL arm_state: got state=%0d flags=%b, required state=1 flags=0000",
               o_state, {o_primed, o_triggered, o_stopped, o_rd_valid});
    end
  endtask

  task automatic write_phase(int upto);
    logic [2:0] es;
    for (int n = 0; n <= upto; n++) begin
      i_data = data_arr[n]; i_ext_trigger = ext_arr[n];
      @(negedge clk);
      if (n < DEPTH - 1)     es = 3'd1;
      else if (n < trig_idx) es = 3'd2;
      else if (n < last_idx) es = 3'd3;
      else                   es = 3'd4;
      checks++;
      if ({o_state, o_primed, o_triggered, o_stopped} !==
          {es, n >= DEPTH - 1, n >= trig_idx, n >= last_idx}) begin
        errors++;
        $display("FAIL write_status n=%0d: got state=%0d p/t/s=%b, required state=%0d p/t/s=%b",
                 n, o_state, {o_primed, o_triggered, o_stopped}, es,
                 {n >= DEPTH - 1, n >= trig_idx, n >= last_idx});
      end
      if (n == last_idx) begin
        checks++;
        if (o_trig_addr !== 4'(DEPTH - 1 - heff)) begin
          errors++;
          $display("FAIL trig_addr: got %0d, required %0d", o_trig_addr, DEPTH - 1 - heff);
        end
      end
    end
    i_ext_trigger = 1'b0;
  endtask

  task automatic readout_phase(bit rnd, int nbeats);
    int beat = 0, cyc = 0;
    bit stalled = 1'b0, rdy;
    logic [7:0] pd = '0;
    logic pl = 1'b0;
    @(negedge clk);
    checks++;
    if ({o_rd_valid, o_state} !== {1'b0, 3'd5}) begin
      errors++;
      $display("FAIL prefetch: got valid=%b state=%0d, required valid=0 state=5", o_rd_valid, o_state);
    end
    @(negedge clk);
    checks++;
    if (o_rd_valid !== 1'b1) begin
      errors++;
      $display("FAIL valid_latency: got valid=%b, required 1", o_rd_valid);
    end
    while (beat < nbeats && cyc < 1000) begin
      if (stalled) begin
        checks++;
        if ({o_rd_valid, o_rd_data, o_rd_last} !== {1'b1, pd, pl}) begin
          errors++;
          $display("FAIL stall_hold: got v/d/l=%b/%h/%b, required 1/%h/%b",
                   o_rd_valid, o_rd_data, o_rd_last, pd, pl);
        end
      end
      rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      i_rd_ready = rdy;
      if (o_rd_valid && rdy) begin
        checks++;
        if ({o_rd_data, o_rd_last} !== {exp_beats[beat], beat == DEPTH - 1}) begin
          errors++;
          $display("FAIL beat %0d: got data=%h last=%b, required data=%h last=%b",
                   beat, o_rd_data, o_rd_last, exp_beats[beat], beat == DEPTH - 1);
        end
        beat++;
      end
      stalled = o_rd_valid && !rdy;
      pd = o_rd_data; pl = o_rd_last;
      @(negedge clk);
      cyc++;
    end
    i_rd_ready = 1'b0;
    checks++;
    if (beat != nbeats) begin
      errors++;
      $display("FAIL readout_timeout: got %0d beats, required %0d", beat, nbeats);
    end
    if (!rnd && nbeats == DEPTH) begin
      checks++;
      if (cyc != DEPTH) begin
        errors++;
        $display("FAIL back_to_back: got %0d cycles, required %0d", cyc, DEPTH);
      end
    end
    if (nbeats == DEPTH) begin
      checks++;
      if ({o_state, o_rd_valid, o_primed, o_triggered, o_stopped} !== {3'd0, 4'b0111}) begin
        errors++;
        $display("FAIL readout_end: got state=%0d v/p/t/s=%b, required state=0 v/p/t/s=0111",
                 o_state, {o_rd_valid, o_primed, o_triggered, o_stopped});
      end
    end
  endtask

  task automatic capture(bit rnd);
    compute_model();
    arm_pulse();
    write_phase(last_idx);
    readout_phase(rnd, DEPTH);
  endtask

  task automatic set_cfg(logic [1:0] md, logic [19:0] h, logic [7:0] mk, logic [7:0] vl);
    mode = md; hold = h; mask = mk; value = vl;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({o_rd_data, o_rd_valid, o_rd_last, o_primed, o_triggered, o_stopped, o_trig_addr, o_state} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got state=%0d data=%h flags=%b, required all zero",
               o_state, o_rd_data, {o_rd_valid, o_rd_last, o_primed, o_triggered, o_stopped});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (o_state !== 3'd0) begin
      errors++;
      $display("FAIL reset_idle: got state=%0d, required 0", o_state);
    end
  endtask

  task automatic test_basic();
    set_cfg(2'd0, 20'd5, 8'h00, 8'h00); fill_count(20);
    capture(1'b0);
    checks++;
    if (o_trig_addr !== 4'd10) begin
      errors++;
      $display("FAIL basic_trig_addr: got %0d, required 10", o_trig_addr);
    end
  endtask

  task automatic test_holdoff_extremes();
    set_cfg(2'd0, 20'd5, 8'h00, 8'h00); fill_count(-1);
    capture(1'b0);
    set_cfg(2'd0, 20'd0, 8'h00, 8'h00); fill_count(20);
    capture(1'b0);
    set_cfg(2'd0, 20'd1000, 8'h00, 8'h00); fill_count(20);
    capture(1'b0);
    checks++;
    if (o_trig_addr !== 4'd0) begin
      errors++;
      $display("FAIL clamp_trig_addr: got %0d, required 0", o_trig_addr);
    end
  endtask

  task automatic test_pattern();
    set_cfg(2'd1, 20'd3, 8'h0F, 8'h05);
    for (int n = 0; n < NARR; n++) begin
      data_arr[n] = 8'($urandom); ext_arr[n] = 1'b1;
    end
    data_arr[40] = 8'hA5;
    capture(1'b0);
    set_cfg(2'd2, 20'd4, 8'h0F, 8'h05);
    for (int n = 0; n < NARR; n++) begin
      data_arr[n] = {4'($urandom), (n >= 30 && n < 34) ? 4'hA : 4'h5};
      ext_arr[n]  = 1'b1;
    end
    capture(1'b0);
    checks++;
    if (trig_idx != 34) begin
      errors++;
      $display("FAIL rising_model: got trigger write %0d, required 34", trig_idx);
    end
  endtask

  task automatic test_backpressure();
    set_cfg(2'd0, 20'd5, 8'h00, 8'h00); fill_count(20);
    capture(1'b1);
  endtask

  task automatic test_rearm();
    set_cfg(2'd0, 20'd5, 8'h00, 8'h00); fill_count(20);
    compute_model();
    arm_pulse();
    write_phase(trig_idx + 2);
    arm_pulse();
    write_phase(last_idx);
    readout_phase(1'b1, 5);
    arm_pulse();
    write_phase(last_idx);
    readout_phase(1'b0, DEPTH);
  endtask

  task automatic test_reset_midfill();
    set_cfg(2'd0, 20'd5, 8'h00, 8'h00); fill_count(20);
    compute_model();
    arm_pulse();
    write_phase(5);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({o_rd_data, o_rd_valid, o_rd_last, o_primed, o_triggered, o_stopped, o_trig_addr, o_state} !== '0) begin
      errors++;
      $display("FAIL async_reset: got state=%0d flags=%b, required all zero",
               o_state, {o_rd_valid, o_rd_last, o_primed, o_triggered, o_stopped});
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({o_state, o_primed} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_stays_idle: got state=%0d primed=%b, required 0/0", o_state, o_primed);
    end
    capture(1'b0);
  endtask

  task automatic test_random();
    for (int it = 0; it < 5; it++) begin
      mode  = 2'($urandom_range(0, 3));
      mask  = 8'($urandom) | 8'h01;
      value = 8'($urandom);
      hold  = ($urandom_range(0, 3) == 0) ? 20'd1000 : 20'($urandom_range(0, 20));
      for (int n = 0; n < NARR; n++) begin
        data_arr[n] = 8'($urandom);
        ext_arr[n]  = ($urandom_range(0, 7) == 0);
      end
      data_arr[198] = value ^ mask;
      data_arr[199] = value;
      ext_arr[199]  = 1'b1;
      capture(1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    rst_n = 1'b0; i_arm = 1'b0; i_rd_ready = 1'b0; i_ext_trigger = 1'b0;
    i_data = '0; i_trig_mode = '0; i_trig_mask = '0; i_trig_value = '0; i_holdoff = '0;
    test_reset();
    test_basic();
    test_holdoff_extremes();
    test_pattern();
    test_backpressure();
    test_rearm();
    test_reset_midfill();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
